// File: rtl/tag_rename_pkg.sv
// Shared definitions for the rename stage and the tagged reservation station:
// instruction field layout, default widths and the register alias table entry.
package tag_rename_pkg;

   localparam int INSTR_WIDTH = 16;
   localparam int REG_WIDTH   = 4;
   localparam int TAG_WIDTH   = 8;
   localparam int DATA_WIDTH  = 128;
   localparam int NUM_TAGS    = 16;

   // Instruction layout: [15:12] opcode, [11:8] dst, [7:4] srca, [3:0] srcb
   localparam int OPC_LSB  = 12;
   localparam int OPC_W    = 4;
   localparam int DST_LSB  = 8;
   localparam int SRCA_LSB = 4;
   localparam int SRCB_LSB = 0;

   typedef struct packed {
      logic                 pending;
      logic [TAG_WIDTH-1:0] tag;
   } rat_entry_t;

endpackage

// File: rtl/tag_rename_free_list.sv
// Circular tag free list, preloaded 0..num_tags-1 on reset; pop reads head, push writes tail.
// A push into a full list is dropped and raises a sticky overflow flag until reset.
module tag_free_list
   import tag_rename_pkg::*;
#(
   parameter int tag_width = TAG_WIDTH,
   parameter int num_tags  = NUM_TAGS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pop_i,
   input  logic                 push_i,
   input  logic [tag_width-1:0] push_tag_i,
   output logic [tag_width-1:0] head_tag_o,
   output logic                 empty_o,
   output logic                 overflow_o
);

   localparam int PTR_W = (num_tags > 1) ? $clog2(num_tags) : 1;
   localparam int CNT_W = $clog2(num_tags + 1);

   logic [tag_width-1:0] slot_q [num_tags];
   logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 overflow_q, overflow_d;
   logic                 full, do_pop, do_push;

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(num_tags - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      full       = (count_q == CNT_W'(num_tags));
      do_pop     = pop_i & (count_q != '0);
      do_push    = push_i & ~full;
      head_d     = do_pop  ? wrap_inc(head_q) : head_q;
      tail_d     = do_push ? wrap_inc(tail_q) : tail_q;
      count_d    = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_W'(1);
      end
      overflow_d = overflow_q | (push_i & full);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < num_tags; i++) begin
            slot_q[i] <= tag_width'(i);
         end
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= CNT_W'(num_tags);
         overflow_q <= 1'b0;
      end else begin
         if (do_push) begin
            slot_q[tail_q] <= push_tag_i;
         end
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign head_tag_o = slot_q[head_q];
   assign empty_o    = (count_q == '0);
   assign overflow_o = overflow_q;

endmodule

// File: rtl/tag_rename.sv
// Rename/issue stage: allocates a result tag, resolves sources via RAT + data file, writes the station 1 cycle after accept.
// Stalls on empty free list or rs_full_IN; TAG_RENAME_BYPASS_EN enables same-cycle broadcast bypass, else bcast_IN also stalls.
module tag_rename
   import tag_rename_pkg::*;
#(
   parameter int instr_width = INSTR_WIDTH,
   parameter int reg_width   = REG_WIDTH,
   parameter int tag_width   = TAG_WIDTH,
   parameter int num_tags    = NUM_TAGS,
   parameter int data_width  = DATA_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   issue_valid_IN,
   output logic                   issue_ready_OUT,
   input  logic [instr_width-1:0] instr_IN,
   input  logic                   rs_full_IN,
   input  logic                   bcast_IN,
   input  logic [tag_width-1:0]   bcast_tag_IN,
   input  logic [data_width-1:0]  bcast_data_IN,
   output logic                   write_entry_OUT,
   output logic [instr_width-1:0] instr_OUT,
   output logic [tag_width-1:0]   instr_tag_OUT,
   output logic [tag_width-1:0]   tag0_OUT,
   output logic [tag_width-1:0]   tag1_OUT,
   output logic [data_width-1:0]  d0_OUT,
   output logic [data_width-1:0]  d1_OUT,
   output logic                   acache_hit_OUT,
   output logic                   bcache_hit_OUT,
   output logic                   err_OUT
);

   localparam int num_regs = 2 ** reg_width;

   rat_entry_t            rat_q  [num_regs];
   logic [data_width-1:0] file_q [num_regs];

   logic [reg_width-1:0]  dst;
   logic [reg_width-1:0]  src    [2];
   logic                  hit_d  [2];
   logic [data_width-1:0] opd_d  [2];
   logic [tag_width-1:0]  stag_d [2];
   logic [tag_width-1:0]  alloc_tag;
   logic                  fl_empty, accept;

   logic                   write_entry_q;
   logic [instr_width-1:0] instr_q;
   logic [tag_width-1:0]   instr_tag_q, tag0_q, tag1_q;
   logic [data_width-1:0]  d0_q, d1_q;
   logic                   ahit_q, bhit_q;

   assign dst    = instr_IN[DST_LSB  +: reg_width];
   assign src[0] = instr_IN[SRCA_LSB +: reg_width];
   assign src[1] = instr_IN[SRCB_LSB +: reg_width];

`ifdef TAG_RENAME_BYPASS_EN
   assign issue_ready_OUT = ~rst & ~fl_empty & ~rs_full_IN;
`else
   // Without bypass a broadcast cannot be captured for an operand issued this cycle, so hold off.
   assign issue_ready_OUT = ~rst & ~fl_empty & ~rs_full_IN & ~bcast_IN;
`endif
   assign accept = issue_valid_IN & issue_ready_OUT;

   tag_free_list #(
      .tag_width (tag_width),
      .num_tags  (num_tags)
   ) u_free_list (
      .clk        (clk),
      .rst        (rst),
      .pop_i      (accept),
      .push_i     (bcast_IN),
      .push_tag_i (bcast_tag_IN),
      .head_tag_o (alloc_tag),
      .empty_o    (fl_empty),
      .overflow_o (err_OUT)
   );

   // Lookups see pre-rename state, so dst == src reads the old mapping.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         hit_d[s]  = 1'b0;
         opd_d[s]  = '0;
         stag_d[s] = '0;
         if (!rat_q[src[s]].pending) begin
            hit_d[s] = 1'b1;
            opd_d[s] = file_q[src[s]];
         end
`ifdef TAG_RENAME_BYPASS_EN
         else if (bcast_IN && rat_q[src[s]].tag == bcast_tag_IN) begin
            hit_d[s] = 1'b1;
            opd_d[s] = bcast_data_IN;
         end
`endif
         else begin
            stag_d[s] = rat_q[src[s]].tag;
         end
      end
   end

   // A same-cycle rename wins over a broadcast retiring the entry's old tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < num_regs; i++) begin
            rat_q[i]  <= '0;
            file_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < num_regs; i++) begin
            if (accept && dst == reg_width'(i)) begin
               rat_q[i].pending <= 1'b1;
               rat_q[i].tag     <= alloc_tag;
            end else if (bcast_IN && rat_q[i].pending && rat_q[i].tag == bcast_tag_IN) begin
               rat_q[i].pending <= 1'b0;
               file_q[i]        <= bcast_data_IN;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         write_entry_q <= 1'b0;
         instr_q       <= '0;
         instr_tag_q   <= '0;
         tag0_q        <= '0;
         tag1_q        <= '0;
         d0_q          <= '0;
         d1_q          <= '0;
         ahit_q        <= 1'b0;
         bhit_q        <= 1'b0;
      end else begin
         write_entry_q <= accept;
         if (accept) begin
            instr_q     <= instr_IN;
            instr_tag_q <= alloc_tag;
            tag0_q      <= stag_d[0];
            tag1_q      <= stag_d[1];
            d0_q        <= opd_d[0];
            d1_q        <= opd_d[1];
            ahit_q      <= hit_d[0];
            bhit_q      <= hit_d[1];
         end
      end
   end

   assign write_entry_OUT = write_entry_q;
   assign instr_OUT       = instr_q;
   assign instr_tag_OUT   = instr_tag_q;
   assign tag0_OUT        = tag0_q;
   assign tag1_OUT        = tag1_q;
   assign d0_OUT          = d0_q;
   assign d1_OUT          = d1_q;
   assign acache_hit_OUT  = ahit_q;
   assign bcache_hit_OUT  = bhit_q;

endmodule
